// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- synchronous FIFO controller with two round-robin write
// producers, one reader, an external combinational-read memory and status flags.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req0/din0, gnt0     producer 0 request, data, same-cycle grant
//   req1/din1, gnt1     producer 1 request, data, same-cycle grant
//   rd_req              read request
//   rd_data, rd_valid   registered read data, one-cycle valid pulse
//   mem_w_en, mem_waddr, mem_wdata   memory write port (addr = wptr)
//   mem_raddr, mem_rdata             memory read port (addr = rptr, comb read)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow  sticky error flags, cleared by clr_err
module fifo_ctrl #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 8,
    parameter int AF_Level   = (2 ** Addr_Width) - 4,
    parameter int AE_Level   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [Data_Width-1:0] din0,
    input  logic                  req1,
    input  logic [Data_Width-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic                  rd_req,
    output logic [Data_Width-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  mem_w_en,
    output logic [Addr_Width:0]   mem_waddr,
    output logic [Data_Width-1:0] mem_wdata,
    output logic [Addr_Width:0]   mem_raddr,
    input  logic [Data_Width-1:0] mem_rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [Addr_Width:0] AF_L = (Addr_Width+1)'(AF_Level);
    localparam logic [Addr_Width:0] AE_L = (Addr_Width+1)'(AE_Level);

    logic [Addr_Width:0] wptr, rptr, cnt;
    logic [Addr_Width:0] wptr_n, rptr_n;
    logic                last_gnt1;   // 1: producer 1 was granted most recently
    logic                full_ptr, empty_ptr;
    logic                wr_acc, rd_acc;
    logic                ovf_evt, unf_evt;

    // Occupancy from the registered pointers (start-of-cycle state)
    assign full_ptr  = (wptr[Addr_Width] != rptr[Addr_Width]) &&
                       (wptr[Addr_Width-1:0] == rptr[Addr_Width-1:0]);
    assign empty_ptr = (wptr == rptr);

    // Reset forces the idle status view during the reset cycle itself
    assign full         = !rst && full_ptr;
    assign empty        = rst || empty_ptr;
    assign almost_full  = !rst && (cnt >= AF_L);
    assign almost_empty = rst || (cnt <= AE_L);
    assign count        = cnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !full_ptr) begin
            // Producer 0 wins alone, or under contention when 1 went last
            if (req0 && (!req1 || last_gnt1))
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    assign wr_acc    = gnt0 | gnt1;
    assign rd_acc    = !rst && rd_req && !empty_ptr;
    assign ovf_evt   = (req0 | req1) && full_ptr;
    assign unf_evt   = rd_req && empty_ptr;

    assign mem_w_en  = wr_acc;
    assign mem_wdata = gnt1 ? din1 : din0;
    assign mem_waddr = wptr;
    assign mem_raddr = rptr;

    assign wptr_n = wptr + (Addr_Width+1)'(wr_acc);
    assign rptr_n = rptr + (Addr_Width+1)'(rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            last_gnt1 <= 1'b1;
        end else begin
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            cnt      <= wptr_n - rptr_n;
            rd_valid <= rd_acc;
            if (rd_acc)
                rd_data <= mem_rdata;
            if (wr_acc)
                last_gnt1 <= gnt1;
            // A new error in the clearing cycle keeps the flag set
            overflow  <= ovf_evt | (overflow  & ~clr_err);
            underflow <= unf_evt | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl -- directed self-checking bench for fifo_ctrl with
// Addr_Width=2 (Depth 4), AF_Level=3, AE_Level=1, and a small memory model.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, req0, req1, rd_req, clr_err;
    logic [7:0] din0, din1;
    logic       gnt0, gnt1, rd_valid, mem_w_en;
    logic [7:0] rd_data, mem_wdata, mem_rdata;
    logic [2:0] mem_waddr, mem_raddr, count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:3];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_w_en) mem[mem_waddr[1:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr[1:0]];

    fifo_ctrl #(
        .Data_Width(8),
        .Addr_Width(2),
        .AF_Level(3),
        .AE_Level(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_w_en(mem_w_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 0; req0 = 0; req1 = 0; rd_req = 0; clr_err = 0;
    endtask

    task automatic do_reset;
        idle(); rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1; req0 = 1; req1 = 1; rd_req = 1; clr_err = 0;
        din0 = 8'hAA; din1 = 8'hBB;
        #1;
        n_cmp++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
        n_cmp++; if (mem_w_en !== 1'b0) begin n_err++; $display("FAIL rst_wen got=%b exp=0", mem_w_en); end
        n_cmp++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_err++; $display("FAIL rst_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
        step();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_cmp++; if ({rd_valid, overflow, underflow} !== 3'b000) begin n_err++; $display("FAIL rst_regs got=%b exp=000", {rd_valid, overflow, underflow}); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
        idle();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            req0 = 1; din0 = 8'h11 + 8'(i);
            #1;
            n_cmp++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_wdata !== din0) begin n_err++; $display("FAIL fill_gnt[%0d] got=%b%b/%h exp=10/%h", i, gnt0, gnt1, mem_wdata, din0); end
            step();
            n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            n_cmp++; if (almost_full !== (i + 1 >= 3)) begin n_err++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 3)); end
            n_cmp++; if (full !== (i == 3)) begin n_err++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 3)); end
        end
        req0 = 1; din0 = 8'h15;
        #1;
        n_cmp++; if (gnt0 !== 1'b0 || mem_w_en !== 1'b0) begin n_err++; $display("FAIL fill_over_gnt got=%b%b exp=00", gnt0, mem_w_en); end
        step();
        n_cmp++; if (overflow !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL fill_overflow got=%b/%0d exp=1/4", overflow, count); end
        idle();
    endtask

    task automatic test_drain;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1;
            step();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h11 + 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'h11 + 8'(i)); end
            n_cmp++; if (count !== 3'(3 - i) || empty !== (i == 3)) begin n_err++; $display("FAIL drain_count[%0d] got=%0d/%b exp=%0d/%b", i, count, empty, 3 - i, (i == 3)); end
        end
        rd_req = 0;
        step();
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h14) begin n_err++; $display("FAIL drain_hold got=%b/%h exp=0/14", rd_valid, rd_data); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL drain_ae got=%b exp=1", almost_empty); end
        rd_req = 1;
        step();
        n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_underflow got=%b/%b exp=1/0", underflow, rd_valid); end
        // clear while a new underflow occurs: overflow clears, underflow holds
        rd_req = 1; clr_err = 1;
        step();
        n_cmp++; if ({overflow, underflow} !== 2'b01) begin n_err++; $display("FAIL clr_precedence got=%b exp=01", {overflow, underflow}); end
        rd_req = 0; clr_err = 1;
        step();
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL clr_done got=%b exp=00", {overflow, underflow}); end
        idle();
    endtask

    task automatic test_contention;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0 = 1; req1 = 1; din0 = 8'hA0 + 8'(i); din1 = 8'hB0 + 8'(i);
            #1;
            n_cmp++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b%b exp=%b", i, gnt0, gnt1, ((i % 2 == 0) ? 2'b10 : 2'b01)); end
            step();
        end
        idle();
        n_cmp++; if (mem[0] !== 8'hA0 || mem[1] !== 8'hB1 || mem[2] !== 8'hA2 || mem[3] !== 8'hB3) begin n_err++; $display("FAIL rr_mem got=%h %h %h %h exp=a0 b1 a2 b3", mem[0], mem[1], mem[2], mem[3]); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL rr_full got=%b exp=1", full); end
    endtask

    task automatic test_boundary;
        rd_req = 1; req0 = 1; din0 = 8'hEE;
        #1;
        n_cmp++; if (gnt0 !== 1'b0 || mem_w_en !== 1'b0) begin n_err++; $display("FAIL bnd_full_gnt got=%b%b exp=00", gnt0, mem_w_en); end
        step();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0 || count !== 3'd3) begin n_err++; $display("FAIL bnd_full_rd got=%b/%h/%0d exp=1/a0/3", rd_valid, rd_data, count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bnd_full_ovf got=%b exp=1", overflow); end
        req0 = 0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (rd_data !== 8'hB3 || empty !== 1'b1) begin n_err++; $display("FAIL bnd_drain got=%h/%b exp=b3/1", rd_data, empty); end
        idle(); clr_err = 1;
        step();
        idle();
        rd_req = 1; req0 = 1; din0 = 8'h55;
        #1;
        n_cmp++; if (gnt0 !== 1'b1 || mem_wdata !== 8'h55) begin n_err++; $display("FAIL bnd_empty_gnt got=%b/%h exp=1/55", gnt0, mem_wdata); end
        step();
        n_cmp++; if (count !== 3'd1 || rd_valid !== 1'b0 || rd_data !== 8'hB3) begin n_err++; $display("FAIL bnd_empty_rd got=%0d/%b/%h exp=1/0/b3", count, rd_valid, rd_data); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL bnd_empty_unf got=%b exp=1", underflow); end
        idle();
    endtask

    task automatic test_wrap_reset;
        do_reset();
        rd_req = 1;
        step();
        idle();
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL wrap_unf got=%b exp=1", underflow); end
        for (int i = 0; i < 10; i++) begin
            req0 = 1; din0 = 8'h30 + 8'(i);
            step();
            req0 = 0;
            n_cmp++; if (full !== 1'b0 || count !== 3'd1) begin n_err++; $display("FAIL wrap_wr[%0d] got=%b/%0d exp=0/1", i, full, count); end
            rd_req = 1;
            step();
            rd_req = 0;
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h30 + 8'(i) || count !== 3'd0) begin n_err++; $display("FAIL wrap_rd[%0d] got=%b/%h/%0d exp=1/%h/0", i, rd_valid, rd_data, count, 8'h30 + 8'(i)); end
        end
        req0 = 1; din0 = 8'h40; step();
        din0 = 8'h41; step();
        idle();
        n_cmp++; if (count !== 3'd2 || mem_waddr !== 3'd4) begin n_err++; $display("FAIL wrap_two got=%0d/%0d exp=2/4", count, mem_waddr); end
        rst = 1; req0 = 1; rd_req = 1;
        #1;
        n_cmp++; if ({gnt0, mem_w_en, empty, full} !== 4'b0010) begin n_err++; $display("FAIL midrst_comb got=%b exp=0010", {gnt0, mem_w_en, empty, full}); end
        step();
        idle();
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || {overflow, underflow, rd_valid} !== 3'b000) begin n_err++; $display("FAIL midrst_regs got=%0d/%b/%b exp=0/1/000", count, empty, {overflow, underflow, rd_valid}); end
        n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_err++; $display("FAIL midrst_almost got=%b%b exp=10", almost_empty, almost_full); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); din0 = '0; din1 = '0;
        test_reset();
        test_fill();
        test_drain();
        test_contention();
        test_boundary();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
